// File: rtl/img_line_buffer.sv
// Multi-line buffer: one vertical column of LINE_NUM taps per accepted pixel, 1-cycle latency.
// Build option LB_EDGE_REPLICATE_EN: replicate frame row 0 into taps above the frame top (default: zero padding).
module img_line_buffer #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int IMG_WIDTH_LINE = 800,
    parameter int LINE_NUM       = 3,
    parameter int ADDR_W         = 11,
    parameter int ROW_W          = 11
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               sof,
    input  logic                               din_valid,
    input  logic [IMG_WIDTH_DATA-1:0]          din,
    output logic                               dout_valid,
    output logic [LINE_NUM*IMG_WIDTH_DATA-1:0] dout,
    output logic                               window_valid,
    output logic [ADDR_W-1:0]                  col_cnt,
    output logic [ROW_W-1:0]                   row_cnt
);
    localparam int MEM_NUM = LINE_NUM - 1;
    localparam int SEL_W   = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam int MEM_AW  = $clog2(IMG_WIDTH_LINE);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH_LINE - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = '1;
    localparam logic [ROW_W-1:0]  ROW_FULL = ROW_W'(LINE_NUM - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(MEM_NUM - 1);

    logic [IMG_WIDTH_DATA-1:0] mem [MEM_NUM][IMG_WIDTH_LINE];

    logic [ADDR_W-1:0]         col, col_eff;
    logic [ROW_W-1:0]          row, row_eff;
    logic [SEL_W-1:0]          wr_sel, sel_eff;
    logic [MEM_AW-1:0]         addr;
    logic [SEL_W-1:0]          rd_sel [LINE_NUM];
    logic [IMG_WIDTH_DATA-1:0] raw    [LINE_NUM];
    logic [IMG_WIDTH_DATA-1:0] tap    [LINE_NUM];

    // A pixel carrying sof is column 0 / row 0 / memory 0 regardless of the old frame position.
    always_comb begin
        col_eff = sof ? '0 : col;
        row_eff = sof ? '0 : row;
        sel_eff = sof ? '0 : wr_sel;
    end

    assign addr = MEM_AW'(col_eff);

    // Tap k lives in memory (wr_sel - k) mod MEM_NUM; tap MEM_NUM is the memory being overwritten.
    always_comb begin
        for (int k = 0; k < LINE_NUM; k++) begin
            if (k == MEM_NUM || k == 0)
                rd_sel[k] = sel_eff;
            else if (sel_eff >= SEL_W'(k))
                rd_sel[k] = sel_eff - SEL_W'(k);
            else
                rd_sel[k] = sel_eff + SEL_W'(MEM_NUM - k);
        end
        raw[0] = din;
        for (int k = 1; k < LINE_NUM; k++)
            raw[k] = mem[rd_sel[k]][addr];
    end

    always_comb begin
        for (int k = 0; k < LINE_NUM; k++) begin
            tap[k] = raw[k];
            if (k > 0 && row_eff < ROW_W'(k)) begin
                tap[k] = '0;
`ifdef LB_EDGE_REPLICATE_EN
                for (int j = 0; j < LINE_NUM; j++)
                    if (row_eff == ROW_W'(j)) tap[k] = raw[j];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col          <= '0;
            row          <= '0;
            wr_sel       <= '0;
            dout_valid   <= 1'b0;
            dout         <= '0;
            window_valid <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
        end else begin
            dout_valid <= din_valid;
            if (din_valid) begin
                for (int k = 0; k < LINE_NUM; k++)
                    dout[k*IMG_WIDTH_DATA +: IMG_WIDTH_DATA] <= tap[k];
                window_valid <= (row_eff >= ROW_FULL);
                col_cnt      <= col_eff;
                row_cnt      <= row_eff;
                if (col_eff == COL_LAST) begin
                    col    <= '0;
                    row    <= (row_eff == ROW_MAX) ? row_eff : row_eff + 1'b1;
                    wr_sel <= (sel_eff == SEL_LAST) ? '0 : sel_eff + 1'b1;
                end else begin
                    col    <= col_eff + 1'b1;
                    row    <= row_eff;
                    wr_sel <= sel_eff;
                end
            end else if (sof) begin
                col    <= '0;
                row    <= '0;
                wr_sel <= '0;
            end
        end
    end

    // NOTE: line memories are deliberately not reset; rows above the frame top are masked so stale data
    // never reaches dout. The non-blocking write also gives read-before-write against the taps above.
    always_ff @(posedge clk) begin
        if (din_valid)
            mem[sel_eff][addr] <= din;
    end

endmodule
